branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/cpu_pkg.sv | 12 +
 rtl/br_target_calc.sv | 19 +
 rtl/branch_resolve.sv | 128 ++++++++++++
 tb/tb_branch_resolve.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-resolve FSM states and fetch step size.
package cpu_pkg;

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SHADOW   = 2'd2
    } br_state_e;

endpackage

// File: rtl/br_target_calc.sv
// Combinational control-flow target: jumps use imm as an absolute address,
// branches use pc + 4 + (imm << 2). Arithmetic wraps modulo 2^NUM_BITS.
module br_target_calc
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_BITS = 32
) (
    input  logic                is_jump,
    input  logic [NUM_BITS-1:0] pc,
    input  logic [NUM_BITS-1:0] imm,
    output logic [NUM_BITS-1:0] target_c
);

    logic [NUM_BITS-1:0] branch_target_c;

    assign branch_target_c = pc + NUM_BITS'(PC_STEP) + (imm << 2);
    assign target_c        = is_jump ? imm : branch_target_c;

endmodule

// File: rtl/branch_resolve.sv
// Branch/jump resolution: decides taken control flow, issues a one-cycle
// fetch redirect and flushes the wrong-path shadow for FLUSH_CYCLES cycles.
// Optional statistics counters are enabled with BRANCH_RESOLVE_STATS_EN.
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_BITS     = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic                is_beq,
    input  logic                is_bne,
    input  logic                is_jump,
    input  logic [NUM_BITS-1:0] pc,
    input  logic [NUM_BITS-1:0] imm,
    input  logic                equal,
    input  logic                not_equal,
    input  logic                stall,
    output logic                redirect,
    output logic [NUM_BITS-1:0] redirect_pc,
    output logic                flush,
    output logic                cmp_err
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [15:0]         br_count,
    output logic [15:0]         taken_count
`endif
);

    localparam int unsigned CNT_W = 2;

    br_state_e           state;
    logic [CNT_W-1:0]    shadow_cnt;
    logic [NUM_BITS-1:0] target_c;
    logic                is_cond_c;
    logic                take_c;
    logic                incons_c;

    br_target_calc #(
        .NUM_BITS (NUM_BITS)
    ) u_target (
        .is_jump  (is_jump),
        .pc       (pc),
        .imm      (imm),
        .target_c (target_c)
    );

    // Jump wins; beq beats bne; an inconsistent compare falls back to equal alone.
    assign is_cond_c = ~is_jump & (is_beq | is_bne);
    assign incons_c  = (equal == not_equal);
    assign take_c    = is_jump | (is_beq & equal) | (~is_beq & is_bne & ~equal);

    // Redirect/flush sequencer; everything freezes while stall is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shadow_cnt  <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            flush       <= 1'b0;
            cmp_err     <= 1'b0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (take_c) begin
                            state       <= REDIRECT;
                            redirect    <= 1'b1;
                            redirect_pc <= target_c;
                            flush       <= 1'b1;
                        end
                        if (is_cond_c && incons_c) begin
                            cmp_err <= 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    redirect <= 1'b0;
                    if (FLUSH_CYCLES <= 1) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        state      <= SHADOW;
                        shadow_cnt <= CNT_W'(FLUSH_CYCLES - 1);
                    end
                end
                SHADOW: begin
                    if (shadow_cnt <= CNT_W'(1)) begin
                        state      <= IDLE;
                        shadow_cnt <= '0;
                        flush      <= 1'b0;
                    end else begin
                        shadow_cnt <= shadow_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    redirect <= 1'b0;
                    flush    <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    logic sample_c;

    assign sample_c = valid_in & ~stall & (state == IDLE) & (is_jump | is_beq | is_bne);

    // Saturating counts of sampled control-flow instructions and taken ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count    <= 16'd0;
            taken_count <= 16'd0;
        end else if (sample_c) begin
            if (br_count != 16'hFFFF) begin
                br_count <= br_count + 16'd1;
            end
            if (take_c && (taken_count != 16'hFFFF)) begin
                taken_count <= taken_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_branch_resolve;

    localparam int NB = 32;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in, is_beq, is_bne, is_jump;
    logic [NB-1:0] pc, imm;
    logic          equal, not_equal, stall;
    logic          redirect;
    logic [NB-1:0] redirect_pc;
    logic          flush;
    logic          cmp_err;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [15:0]   br_count, taken_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural model: remaining flush cycles, expected redirect state.
    int          m_left;
    bit          m_redir;
    logic [31:0] m_pc;
    bit          m_err;

    always #5 clk = ~clk;

    branch_resolve #(
        .NUM_BITS     (NB),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .is_beq      (is_beq),
        .is_bne      (is_bne),
        .is_jump     (is_jump),
        .pc          (pc),
        .imm         (imm),
        .equal       (equal),
        .not_equal   (not_equal),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .cmp_err     (cmp_err)
`ifdef BRANCH_RESOLVE_STATS_EN
        ,
        .br_count    (br_count),
        .taken_count (taken_count)
`endif
    );

    typedef struct {
        bit          v, beq, bne, jmp;
        logic [31:0] p, i;
        bit          eq, ne, st;
        bit          e_redir;
        logic [31:0] e_pc;
        bit          e_flush, e_err;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [31:0] ref_target(input bit jump, input logic [31:0] p,
                                               input logic [31:0] i);
        longint unsigned sum;
        logic [63:0]     full;
        if (jump) return i;
        sum  = longint'(p) + 64'd4 + longint'(i) * 64'd4;
        full = sum;
        return full[31:0];
    endfunction

    task automatic model_reset();
        m_left  = 0;
        m_redir = 0;
        m_pc    = 32'h0;
        m_err   = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit t;
        if (rst) begin
            model_reset();
        end else if (!stall) begin
            if (m_left == 0) begin
                m_redir = 0;
                if (valid_in && (is_jump || is_beq || is_bne)) begin
                    if (is_jump) begin
                        t = 1;
                    end else begin
                        if (equal == not_equal) m_err = 1;
                        if (is_beq)                  t = equal;
                        else if (equal == not_equal) t = !equal;
                        else                         t = not_equal;
                    end
                    if (t) begin
                        m_redir = 1;
                        m_pc    = ref_target(is_jump, pc, imm);
                        m_left  = FC;
                    end
                end
            end else begin
                m_redir = 0;
                m_left  = m_left - 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " redirect"},    32'(redirect),    32'(m_redir));
        check({tag, " flush"},       32'(flush),       32'(m_left > 0));
        check({tag, " cmp_err"},     32'(cmp_err),     32'(m_err));
        check({tag, " redirect_pc"}, redirect_pc,      m_pc);
    endtask

    task automatic set_in(input bit v, input bit beq, input bit bne, input bit jmp,
                          input logic [31:0] p, input logic [31:0] i,
                          input bit eq, input bit ne, input bit st);
        valid_in  = v;
        is_beq    = beq;
        is_bne    = bne;
        is_jump   = jmp;
        pc        = p;
        imm       = i;
        equal     = eq;
        not_equal = ne;
        stall     = st;
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    endtask

    initial begin
        int pulses;
        int flush_cycles;
        bit prev_redir;

        tbl[0]  = '{1,1,0,0, 32'h100, 32'd4,   1,0,0, 1, 32'h114, 1, 0};
        tbl[1]  = '{0,0,0,0, 32'h0,   32'h0,   0,1,0, 0, 32'h114, 1, 0};
        tbl[2]  = '{0,0,0,0, 32'h0,   32'h0,   0,1,0, 0, 32'h114, 0, 0};
        tbl[3]  = '{1,0,1,0, 32'h200, 32'd8,   1,0,0, 0, 32'h114, 0, 0};
        tbl[4]  = '{0,0,0,0, 32'h0,   32'h0,   0,1,0, 0, 32'h114, 0, 0};
        tbl[5]  = '{0,0,0,0, 32'h0,   32'h0,   0,1,0, 0, 32'h114, 0, 0};
        tbl[6]  = '{0,0,0,0, 32'h0,   32'h0,   0,1,0, 0, 32'h114, 0, 0};
        tbl[7]  = '{1,0,0,1, 32'h300, 32'h400, 0,1,0, 1, 32'h400, 1, 0};
        tbl[8]  = '{1,1,0,0, 32'h0,   32'h0,   1,0,0, 0, 32'h400, 1, 0};
        tbl[9]  = '{0,0,0,0, 32'h0,   32'h0,   0,1,0, 0, 32'h400, 0, 0};
        tbl[10] = '{0,0,0,0, 32'h0,   32'h0,   0,1,0, 0, 32'h400, 0, 0};

        // Reset state
        rst = 1'b1;
        idle_in();
        model_reset();
        step();
        step();
        check("reset redirect",    32'(redirect), 32'd0);
        check("reset redirect_pc", redirect_pc,   32'd0);
        check("reset flush",       32'(flush),    32'd0);
        check("reset cmp_err",     32'(cmp_err),  32'd0);
        rst = 1'b0;

        // Directed vectors: taken beq, not-taken bne, jump with shadowed beq
        for (int k = 0; k < 11; k++) begin
            set_in(tbl[k].v, tbl[k].beq, tbl[k].bne, tbl[k].jmp, tbl[k].p, tbl[k].i,
                   tbl[k].eq, tbl[k].ne, tbl[k].st);
            step();
            check($sformatf("vec%0d redirect", k),    32'(redirect), 32'(tbl[k].e_redir));
            check($sformatf("vec%0d redirect_pc", k), redirect_pc,   tbl[k].e_pc);
            check($sformatf("vec%0d flush", k),       32'(flush),    32'(tbl[k].e_flush));
            check($sformatf("vec%0d cmp_err", k),     32'(cmp_err),  32'(tbl[k].e_err));
        end

        // Stall held over the redirect cycle: one pulse, five flush cycles
        pulses       = 0;
        flush_cycles = 0;
        prev_redir   = 0;
        set_in(1, 1, 0, 0, 32'h10, 32'd1, 1, 0, 0);
        for (int k = 0; k < 7; k++) begin
            step();
            if (k == 0) idle_in();
            if (k == 0) stall = 1'b1;
            if (k == 3) stall = 1'b0;
            if (redirect && !prev_redir) pulses++;
            prev_redir = redirect;
            if (flush) flush_cycles++;
            if (k <= 3) begin
                check($sformatf("stall redirect c%0d", k),    32'(redirect), 32'd1);
                check($sformatf("stall redirect_pc c%0d", k), redirect_pc,   32'h18);
            end else begin
                check($sformatf("stall redirect c%0d", k), 32'(redirect), 32'd0);
            end
        end
        check("stall pulse count",  32'(pulses),       32'd1);
        check("stall flush cycles", 32'(flush_cycles), 32'd5);

        // Target wrap-around
        set_in(1, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 1, 0, 0);
        step();
        idle_in();
        check("wrap redirect",    32'(redirect), 32'd1);
        check("wrap redirect_pc", redirect_pc,   32'h0);
        step();
        step();
        check("wrap flush done",  32'(flush),    32'd0);

        // Inconsistent compare sets sticky cmp_err; decision follows equal
        set_in(1, 1, 0, 0, 32'h20, 32'h0, 1, 1, 0);
        step();
        idle_in();
        check("cmp_err set",         32'(cmp_err),  32'd1);
        check("cmp_err redirect",    32'(redirect), 32'd1);
        check("cmp_err redirect_pc", redirect_pc,   32'h24);
        for (int k = 0; k < 3; k++) step();
        check("cmp_err sticky",      32'(cmp_err),  32'd1);

        // Reset during shadow, then a branch right after release
        set_in(1, 1, 0, 0, 32'h40, 32'd2, 1, 0, 0);
        step();
        idle_in();
        check("pre-rst redirect_pc", redirect_pc, 32'h4C);
        step();
        check("pre-rst flush", 32'(flush), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("async rst flush",       32'(flush),    32'd0);
        check("async rst redirect",    32'(redirect), 32'd0);
        check("async rst cmp_err",     32'(cmp_err),  32'd0);
        check("async rst redirect_pc", redirect_pc,   32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1, 1, 0, 0, 32'h80, 32'h0, 1, 0, 0);
        step();
        idle_in();
        check("post-rst redirect",    32'(redirect), 32'd1);
        check("post-rst redirect_pc", redirect_pc,   32'h84);
        check("post-rst flush",       32'(flush),    32'd1);
        step();
        step();
        check_model("post-rst settle");

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            bit [2:0] cls;
            bit       eq;
            rst      = ($urandom_range(0, 99) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            valid_in = $urandom_range(0, 1);
            cls      = 3'($urandom_range(0, 7));
            is_jump  = cls[2];
            is_beq   = cls[1];
            is_bne   = cls[0];
            eq       = $urandom_range(0, 1);
            equal    = eq;
            if (!is_jump && ($urandom_range(0, 15) == 0)) not_equal = eq;
            else                                          not_equal = !eq;
            pc       = $urandom;
            imm      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            step();
            check_model($sformatf("rand%0d", k));
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
